// File: rtl/jtag_pkg.sv
// jtag_pkg
//   Shared JTAG definitions: the 16 IEEE 1149.1 TAP state codes and a small
//   helper that classifies states as belonging to the IR column. Imported by
//   the TAP controller and by the IR/DR register logic downstream.
package jtag_pkg;

    localparam int TAP_STATE_W = 4;

    // Standard IEEE 1149.1 state encoding. Downstream logic may compare
    // against these codes directly, so the values must not change.
    typedef enum logic [TAP_STATE_W-1:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_t;

    // True for every state in the IR column, SEL_IR included.
    function automatic logic is_ir_state(input tap_state_t s);
        logic ir;
        ir = 1'b0;
        case (s)
            SEL_IR, CAP_IR, SH_IR, EX1_IR,
            PAU_IR, EX2_IR, UPD_IR: ir = 1'b1;
            default:                ir = 1'b0;
        endcase
        return ir;
    endfunction

endpackage

// File: rtl/tap_controller.sv
// tap_controller
//   IEEE 1149.1 TAP controller. A 16-state FSM stepped by TMS on every rising
//   TCK edge; all outputs are a Moore decode of the state register.
// Ports
//   TCK        in   sole clock, state changes on the rising edge
//   TRST       in   synchronous active-high reset, overrides TMS
//   TMS        in   test mode select, sampled on rising TCK
//   state      out  current 4-bit TAP state code
//   tlr        out  TEST_LOGIC_RESET
//   run_idle   out  RUN_TEST_IDLE
//   capture_dr out  CAPTURE_DR
//   shift_dr   out  SHIFT_DR
//   update_dr  out  UPDATE_DR
//   capture_ir out  CAPTURE_IR
//   shift_ir   out  SHIFT_IR
//   update_ir  out  UPDATE_IR
//   select_ir  out  any IR-column state; steers TDO to the IR path
//   tdo_en     out  SHIFT_DR or SHIFT_IR
module tap_controller
    import jtag_pkg::*;
(
    input  logic                   TCK,
    input  logic                   TRST,
    input  logic                   TMS,
    output logic [TAP_STATE_W-1:0] state,
    output logic                   tlr,
    output logic                   run_idle,
    output logic                   capture_dr,
    output logic                   shift_dr,
    output logic                   update_dr,
    output logic                   capture_ir,
    output logic                   shift_ir,
    output logic                   update_ir,
    output logic                   select_ir,
    output logic                   tdo_en
);

    tap_state_t state_reg;
    tap_state_t state_next;

    // State register. TRST wins over TMS, so a reset mid-scan lands in TLR
    // without passing through any UPDATE state.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            state_reg <= TLR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. The DR and IR columns have identical shapes.
    always_comb begin
        state_next = TLR;
        case (state_reg)
            TLR:    state_next = TMS ? TLR    : RTI;
            RTI:    state_next = TMS ? SEL_DR : RTI;
            SEL_DR: state_next = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_next = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_next = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_next = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_next = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_next = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_next = TMS ? SEL_DR : RTI;
            SEL_IR: state_next = TMS ? TLR    : CAP_IR;
            CAP_IR: state_next = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_next = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_next = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_next = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_next = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_next = TMS ? SEL_DR : RTI;
            // An unknown or corrupted state recovers to TLR.
            default: state_next = TLR;
        endcase
    end

    // Moore output decode; no registering, so strobes may glitch between
    // state codes.
    always_comb begin
        state      = state_reg;
        tlr        = (state_reg == TLR);
        run_idle   = (state_reg == RTI);
        capture_dr = (state_reg == CAP_DR);
        shift_dr   = (state_reg == SH_DR);
        update_dr  = (state_reg == UPD_DR);
        capture_ir = (state_reg == CAP_IR);
        shift_ir   = (state_reg == SH_IR);
        update_ir  = (state_reg == UPD_IR);
        select_ir  = is_ir_state(state_reg);
        tdo_en     = (state_reg == SH_DR) || (state_reg == SH_IR);
    end

endmodule

// File: tb/tb_tap_controller.sv
// tb_tap_controller
//   Directed scans plus a random TMS/TRST walk for tap_controller, checked
//   against a table-driven reference of the TAP state diagram.
module tb_tap_controller;

    logic       TCK;
    logic       TRST;
    logic       TMS;
    logic [3:0] state;
    logic       tlr, run_idle, capture_dr, shift_dr, update_dr;
    logic       capture_ir, shift_ir, update_ir, select_ir, tdo_en;

    tap_controller dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .state      (state),
        .tlr        (tlr),
        .run_idle   (run_idle),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .select_ir  (select_ir),
        .tdo_en     (tdo_en)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    int errors = 0;
    int checks = 0;

    // Reference model: state diagram as two lookup tables (TMS=0 / TMS=1).
    logic [3:0] nx0 [16];
    logic [3:0] nx1 [16];
    logic [3:0] model_state;
    int         ones_run;
    int         shift_dr_cycles;
    int         capture_dr_cycles;
    int         update_dr_cycles;
    int         update_pulses;

    task automatic add_edge(input logic [3:0] s, input logic [3:0] n0, input logic [3:0] n1);
        nx0[s] = n0;
        nx1[s] = n1;
    endtask

    function automatic logic [9:0] expected_outputs(input logic [3:0] s);
        logic ir_col;
        ir_col = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
                 (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
        return {s == 4'hF, s == 4'hC, s == 4'h6, s == 4'h2, s == 4'h5,
                s == 4'hE, s == 4'hA, s == 4'hD, ir_col, (s == 4'h2) || (s == 4'hA)};
    endfunction

    // One TCK edge: drive at the falling edge, advance the model at the rising
    // edge, compare 1 ns later.
    task automatic step(input logic tms, input logic trst, input string tag);
        logic [9:0] got;
        logic [9:0] want;
        @(negedge TCK);
        TMS  = tms;
        TRST = trst;
        @(posedge TCK);
        if (trst) begin
            model_state = 4'hF;
            ones_run    = 0;
        end else begin
            model_state = tms ? nx1[model_state] : nx0[model_state];
            ones_run    = tms ? ones_run + 1 : 0;
        end
        #1;
        got  = {tlr, run_idle, capture_dr, shift_dr, update_dr,
                capture_ir, shift_ir, update_ir, select_ir, tdo_en};
        want = expected_outputs(model_state);
        checks++;
        assert (state === model_state)
            else begin
                errors++;
                $error("FAIL %s state: got %h want %h", tag, state, model_state);
            end
        checks++;
        assert (got === want)
            else begin
                errors++;
                $error("FAIL %s strobes: got %b want %b", tag, got, want);
            end
        if (shift_dr === 1'b1)   shift_dr_cycles++;
        if (capture_dr === 1'b1) capture_dr_cycles++;
        if (update_dr === 1'b1)  update_dr_cycles++;
        if (update_dr === 1'b1 || update_ir === 1'b1) update_pulses++;
        $display("step %-10s TRST=%0d TMS=%0d state=%h", tag, trst, tms, state);
    endtask

    // Step and also compare against a literal code from the state diagram.
    task automatic step_expect(input logic tms, input logic [3:0] code, input string tag);
        step(tms, 1'b0, tag);
        checks++;
        assert (state === code)
            else begin
                errors++;
                $error("FAIL %s code: got %h want %h", tag, state, code);
            end
    endtask

    initial begin
        logic [7:0]  dr_tms;
        logic [3:0]  dr_codes [8];
        logic [9:0]  ir_tms;
        logic [3:0]  ir_codes [10];

        add_edge(4'hF, 4'hC, 4'hF);  // TLR
        add_edge(4'hC, 4'hC, 4'h7);  // RTI
        add_edge(4'h7, 4'h6, 4'h4);  // SEL_DR
        add_edge(4'h4, 4'hE, 4'hF);  // SEL_IR
        add_edge(4'h6, 4'h2, 4'h1);  // CAP_DR
        add_edge(4'h2, 4'h2, 4'h1);  // SH_DR
        add_edge(4'h1, 4'h3, 4'h5);  // EX1_DR
        add_edge(4'h3, 4'h3, 4'h0);  // PAU_DR
        add_edge(4'h0, 4'h2, 4'h5);  // EX2_DR
        add_edge(4'h5, 4'hC, 4'h7);  // UPD_DR
        add_edge(4'hE, 4'hA, 4'h9);  // CAP_IR
        add_edge(4'hA, 4'hA, 4'h9);  // SH_IR
        add_edge(4'h9, 4'hB, 4'hD);  // EX1_IR
        add_edge(4'hB, 4'hB, 4'h8);  // PAU_IR
        add_edge(4'h8, 4'hA, 4'hD);  // EX2_IR
        add_edge(4'hD, 4'hC, 4'h7);  // UPD_IR

        model_state = 4'hF;
        ones_run    = 0;
        TMS  = 1'b0;
        TRST = 1'b0;

        // Reset, then TMS=1 holds TLR.
        step(1'b0, 1'b1, "reset");
        step_expect(1'b1, 4'hF, "tlr_hold");

        // TLR -> RTI and idle there.
        step_expect(1'b0, 4'hC, "to_rti");
        step_expect(1'b0, 4'hC, "rti_1");
        step_expect(1'b0, 4'hC, "rti_2");

        // RTI -> SEL_DR -> SEL_IR -> TLR, then stay.
        step_expect(1'b1, 4'h7, "sel_dr");
        step_expect(1'b1, 4'h4, "sel_ir");
        step_expect(1'b1, 4'hF, "sel_tlr");
        for (int i = 0; i < 7; i++) step_expect(1'b1, 4'hF, "tlr_keep");

        // DR scan from RTI.
        step_expect(1'b0, 4'hC, "to_rti");
        dr_tms   = 8'b0110_0001;  // applied LSB first: 1,0,0,0,0,1,1,0
        dr_codes = '{4'h7, 4'h6, 4'h2, 4'h2, 4'h2, 4'h1, 4'h5, 4'hC};
        shift_dr_cycles   = 0;
        capture_dr_cycles = 0;
        update_dr_cycles  = 0;
        for (int i = 0; i < 8; i++) step_expect(dr_tms[i], dr_codes[i], "dr_scan");
        checks++;
        assert (shift_dr_cycles == 3)
            else begin
                errors++;
                $error("FAIL dr_shift_len: got %0d want 3", shift_dr_cycles);
            end
        checks++;
        assert (capture_dr_cycles == 1 && update_dr_cycles == 1)
            else begin
                errors++;
                $error("FAIL dr_pulse_len: got cap=%0d upd=%0d want 1/1",
                       capture_dr_cycles, update_dr_cycles);
            end

        // IR scan from RTI.
        ir_tms   = 10'b11_0101_0011;  // LSB first: 1,1,0,0,1,0,1,0,1,1
        ir_codes = '{4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hA, 4'h9, 4'hD};
        for (int i = 0; i < 10; i++) step_expect(ir_tms[i], ir_codes[i], "ir_scan");

        // TRST mid-shift aborts with no update pulse.
        step_expect(1'b1, 4'h7, "to_sel_dr");
        step_expect(1'b0, 4'h6, "cap_dr");
        step_expect(1'b0, 4'h2, "sh_dr");
        update_pulses = 0;
        step(1'b1, 1'b1, "trst_shift");
        step(1'b0, 1'b1, "trst_hold");
        checks++;
        assert (state === 4'hF && update_pulses == 0)
            else begin
                errors++;
                $error("FAIL trst_abort: got state=%h updates=%0d want F/0", state, update_pulses);
            end

        // PAU_IR then five TMS=1 reach TLR.
        step_expect(1'b0, 4'hC, "to_rti");
        step_expect(1'b1, 4'h7, "sel_dr");
        step_expect(1'b1, 4'h4, "sel_ir");
        step_expect(1'b0, 4'hE, "cap_ir");
        step_expect(1'b1, 4'h9, "ex1_ir");
        step_expect(1'b0, 4'hB, "pau_ir");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "five_ones");
        checks++;
        assert (state === 4'hF)
            else begin
                errors++;
                $error("FAIL pau_ir_escape: got %h want F", state);
            end

        // Random walk; TRST occasionally. Any run of 5+ TMS=1 must sit in TLR.
        for (int i = 0; i < 400; i++) begin
            logic rtms;
            logic rtrst;
            rtms  = ($urandom_range(0, 99) < 55);
            rtrst = ($urandom_range(0, 31) == 0);
            step(rtms, rtrst, "random");
            if (ones_run >= 5) begin
                checks++;
                assert (state === 4'hF)
                    else begin
                        errors++;
                        $error("FAIL random_five_ones: got %h want F", state);
                    end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
